dfp_responder: RTL and testbench
================================

DFP_RESPONDER -- requirements
Module: dfp_responder

Interface
REQ-001 Parameter LATENCY, default 4, cycles from request acceptance to dfp_resp; legal range 1..15.
REQ-002 Parameter LINES, default 16, number of 256-bit lines held; power of two, 2..64.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 dfp_addr  input  32  byte address of requested line.
REQ-006 dfp_read  input  1  line read request, held by initiator until dfp_resp.
REQ-007 dfp_write  input  1  line write request, held by initiator until dfp_resp.
REQ-008 dfp_wdata  input  256  write line data, valid while dfp_write is high.
REQ-009 dfp_rdata  output  256  read line data, valid only while dfp_resp is high after a read.
REQ-010 dfp_resp  output  1  single-cycle completion pulse.
REQ-011 busy  output  1  high in BUSY and RESP states.
REQ-012 err  output  1  sticky protocol-violation flag.

Function
REQ-013 The block SHALL implement states IDLE, BUSY and RESP.
REQ-014 IDLE, with exactly one of dfp_read/dfp_write high: latch addr, op, wdata; load counter with LATENCY-1; go to BUSY, or to RESP if LATENCY=1.
REQ-015 BUSY: decrement counter each cycle; at counter 0, go to RESP on the next edge.
REQ-016 Timing: request first seen in IDLE in cycle 0 -> dfp_resp high in cycle LATENCY, for exactly one cycle.
REQ-017 RESP: assert dfp_resp; reads drive dfp_rdata from the latched line; writes commit latched wdata to the line at the end of the RESP cycle; return to IDLE.
REQ-018 Line index = latched dfp_addr[5+log2(LINES)-1:5]; upper address bits alias (modulo LINES).
REQ-019 A request with dfp_addr[4:0] nonzero SHALL set err and be served as if aligned.
REQ-020 dfp_read and dfp_write both high in IDLE SHALL set err, be ignored, and leave the state at IDLE.
REQ-021 In BUSY, a change of dfp_addr or op, or request deassertion, SHALL set err; the latched request completes unchanged.
REQ-022 A request high in IDLE in the cycle after RESP SHALL be treated as a new request; no idle gap is required.
REQ-023 dfp_rdata SHALL be 0 whenever dfp_resp is low or the completing op is a write.
REQ-024 Only the single latched request is tracked; requests arriving while busy are not queued.

Reset
REQ-025 Asserting rst SHALL immediately force state IDLE, dfp_resp=0, busy=0, err=0, dfp_rdata=0, counter=0, and every line to 0.
REQ-026 rst mid-transaction SHALL abort it with no write committed and no dfp_resp pulse.
REQ-027 The first request SHALL be sampled on the first rising edge after rst deasserts.

Verification
REQ-028 LATENCY=4: write 0x1234...(256b) to addr 0x40, then read 0x40 -> each dfp_resp exactly in cycle 4 of its request, read dfp_rdata equals written data, err=0.
REQ-029 LATENCY=1, LINES=16: back-to-back reads to 0x00 and 0x200 with no idle gap -> resp in cycles 1 and 3, both return line 0 (alias), err=0.
REQ-030 dfp_read=dfp_write=1 at addr 0x80 -> err=1, no dfp_resp within 20 cycles, line 4 unchanged.
REQ-031 Read at addr 0x47 -> err=1, dfp_rdata equals line 2 contents, resp at cycle LATENCY.
REQ-032 Write 0xFF..FF to 0x20 and assert rst in cycle 2 of BUSY -> no dfp_resp, busy=0 immediately, subsequent read of 0x20 returns 0.
REQ-033 Change dfp_addr 0x60->0xA0 mid-BUSY on a read -> err=1, returned data is line 3.

Source files
------------

// File: rtl/dfp_if.sv
// Line-transfer bus between an initiator (master) and the dfp_responder (slave).
interface dfp_if;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;

  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp
  );

  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp
  );
endinterface

// File: rtl/dfp_responder.sv
// Fixed-latency line memory responder: serves one latched read/write at a time,
// with a one-cycle completion pulse and a sticky protocol-violation flag.
module dfp_responder #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned LINES   = 16
) (
  input  logic     clk,
  input  logic     rst,
  dfp_if.slave     dfp,
  output logic     busy,
  output logic     err
);

  localparam int unsigned IdxW = $clog2(LINES);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  logic           op_wr_q, op_wr_d;
  logic [255:0]   wdata_q, wdata_d;
  logic           err_q, err_d;
  logic [255:0]   mem_q [LINES];

  logic [IdxW-1:0] idx;
  logic            held_ok;

  assign idx = addr_q[5 +: IdxW];

  // The initiator must hold the exact request it issued until completion.
  assign held_ok = (dfp.dfp_addr == addr_q) && (dfp.dfp_write == op_wr_q) &&
                   (dfp.dfp_read == !op_wr_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    op_wr_d = op_wr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (dfp.dfp_read && dfp.dfp_write) begin
          err_d = 1'b1;
        end else if (dfp.dfp_read || dfp.dfp_write) begin
          addr_d  = dfp.dfp_addr;
          op_wr_d = dfp.dfp_write;
          wdata_d = dfp.dfp_wdata;
          if (dfp.dfp_addr[4:0] != 5'd0) begin
            err_d = 1'b1;
          end
          if (LATENCY <= 1) begin
            cnt_d   = 4'd0;
            state_d = StResp;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        // Counter holds the BUSY cycles still to go, so the pulse lands in cycle LATENCY.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StResp;
        end
        if (!held_ok) begin
          err_d = 1'b1;
        end
      end
      StResp: begin
        cnt_d   = 4'd0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      op_wr_q <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      op_wr_q <= op_wr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(LINES); i++) begin
        mem_q[i] <= '0;
      end
    end else if (state_q == StResp && op_wr_q) begin
      mem_q[idx] <= wdata_q;
    end
  end

  always_comb begin
    dfp.dfp_resp  = (state_q == StResp);
    dfp.dfp_rdata = '0;
    if (state_q == StResp && !op_wr_q) begin
      dfp.dfp_rdata = mem_q[idx];
    end
    busy = (state_q != StIdle);
    err  = err_q;
  end

endmodule

// File: tb/tb_dfp_responder.sv
// Randomized self-checking bench: two responders (latency 4 and 1) against a line-array model.
module tb_dfp_responder;

  logic clk;
  logic rst;
  logic busy0, err0, busy1, err1;

  dfp_if bus0 ();
  dfp_if bus1 ();

  dfp_responder #(.LATENCY(4), .LINES(16)) u_dut0 (
    .clk  (clk),
    .rst  (rst),
    .dfp  (bus0),
    .busy (busy0),
    .err  (err0)
  );

  dfp_responder #(.LATENCY(1), .LINES(16)) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .dfp  (bus1),
    .busy (busy1),
    .err  (err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [255:0] mline [2][16];
  bit           merr  [2];
  int           lat   [2] = '{4, 1};

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    for (int s = 0; s < 2; s++) begin
      merr[s] = 1'b0;
      for (int i = 0; i < 16; i++) mline[s][i] = '0;
    end
  endtask

  function automatic int midx(input logic [31:0] a);
    return int'(a[8:5]);
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [255:0] wd);
    if (sel == 0) begin
      bus0.dfp_read = rd; bus0.dfp_write = wr; bus0.dfp_addr = a; bus0.dfp_wdata = wd;
    end else begin
      bus1.dfp_read = rd; bus1.dfp_write = wr; bus1.dfp_addr = a; bus1.dfp_wdata = wd;
    end
  endtask

  function automatic logic get_resp(input int sel);
    return (sel == 0) ? bus0.dfp_resp : bus1.dfp_resp;
  endfunction
  function automatic logic [255:0] get_rdata(input int sel);
    return (sel == 0) ? bus0.dfp_rdata : bus1.dfp_rdata;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 0) ? err0 : err1;
  endfunction

  task automatic idle_all();
    drive(0, 1'b0, 1'b0, 32'd0, '0);
    drive(1, 1'b0, 1'b0, 32'd0, '0);
    @(posedge clk); #1;
  endtask

  // Called #1 after a rising edge with the DUT in IDLE; that cycle is cycle 0.
  // Optionally moves the address at cycle 2 to provoke a held-request violation.
  task automatic run_req(input int sel, input bit wr, input logic [31:0] a,
                         input logic [255:0] wd, input bit chg, input logic [31:0] a2);
    int rc;
    int c;
    logic [255:0] exp_rd;
    rc = -1;
    c  = 0;
    exp_rd = wr ? '0 : mline[sel][midx(a)];
    if (a[4:0] != 5'd0) merr[sel] = 1'b1;
    drive(sel, !wr, wr, a, wd);
    while (c < 20 && rc < 0) begin
      if (chg && c == 2) begin
        drive(sel, !wr, wr, a2, wd);
        merr[sel] = 1'b1;
      end
      @(negedge clk);
      if (c == 0) begin
        check("idle_busy", get_busy(sel), 1'b0);
        check("idle_resp", get_resp(sel), 1'b0);
      end
      if (c == 1) check("busy_high", get_busy(sel), 1'b1);
      if (get_resp(sel)) begin
        rc = c;
        check("rdata", get_rdata(sel), exp_rd);
        check("err", get_err(sel), merr[sel]);
      end
      @(posedge clk); #1;
      c++;
    end
    check("resp_cycle", rc, lat[sel]);
    if (wr) mline[sel][midx(a)] = wd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    reset_model();
    check("rst_busy0", busy0, 1'b0);
    check("rst_resp0", bus0.dfp_resp, 1'b0);
    check("rst_err0", err0, 1'b0);
    check("rst_rdata0", bus0.dfp_rdata, '0);
    check("rst_busy1", busy1, 1'b0);
    drive(0, 1'b0, 1'b0, 32'd0, '0);
    drive(1, 1'b0, 1'b0, 32'd0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    bit saw;
    int sel, prev_sel;
    bit wr;
    logic [31:0] a;
    logic [255:0] pat;

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, '0);
    drive(1, 1'b0, 1'b0, 32'd0, '0);
    @(posedge clk); #1;
    do_reset();

    // Write then read back on the latency-4 responder, no gap.
    pat = {16{16'h1234}};
    run_req(0, 1'b1, 32'h40, pat, 1'b0, 32'd0);
    run_req(0, 1'b0, 32'h40, '0, 1'b0, 32'd0);
    idle_all();
    check("err_clean0", err0, 1'b0);

    // Latency 1: line 0 and its alias at 0x200 read back-to-back.
    run_req(1, 1'b1, 32'h0, rand_line(), 1'b0, 32'd0);
    run_req(1, 1'b0, 32'h0, '0, 1'b0, 32'd0);
    run_req(1, 1'b0, 32'h200, '0, 1'b0, 32'd0);
    idle_all();
    check("err_clean1", err1, 1'b0);

    // Misaligned read of line 2.
    run_req(0, 1'b1, 32'h40, rand_line(), 1'b0, 32'd0);
    run_req(0, 1'b0, 32'h47, '0, 1'b0, 32'd0);
    idle_all();
    check("err_misalign", err0, 1'b1);

    // Address moved mid-BUSY still returns line 3.
    run_req(0, 1'b1, 32'h60, rand_line(), 1'b0, 32'd0);
    run_req(0, 1'b1, 32'hA0, rand_line(), 1'b0, 32'd0);
    run_req(0, 1'b0, 32'h60, '0, 1'b1, 32'hA0);
    idle_all();

    // Read and write together: ignored, flagged, line 4 untouched.
    run_req(0, 1'b1, 32'h80, rand_line(), 1'b0, 32'd0);
    idle_all();
    do_reset();
    drive(0, 1'b1, 1'b1, 32'h80, rand_line());
    merr[0] = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.dfp_resp || busy0) saw = 1'b1;
    end
    check("both_no_resp", saw, 1'b0);
    check("both_err", err0, 1'b1);
    @(posedge clk); #1;
    idle_all();
    run_req(0, 1'b0, 32'h80, '0, 1'b0, 32'd0);
    idle_all();

    // Reset during BUSY aborts the write.
    drive(0, 1'b0, 1'b1, 32'h20, {256{1'b1}});
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset();
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus0.dfp_resp) saw = 1'b1;
    end
    check("abort_no_resp", saw, 1'b0);
    @(posedge clk); #1;
    run_req(0, 1'b0, 32'h20, '0, 1'b0, 32'd0);
    idle_all();

    // Random traffic on both responders.
    prev_sel = 0;
    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(1, 0));
      wr  = 1'($urandom_range(1, 0));
      a   = $urandom;
      if ($urandom_range(3, 0) != 0) a[4:0] = 5'd0;
      if (sel != prev_sel || $urandom_range(1, 0) == 0) idle_all();
      run_req(sel, wr, a, rand_line(), 1'b0, 32'd0);
      prev_sel = sel;
    end
    idle_all();
    check("final_err0", err0, merr[0]);
    check("final_err1", err1, merr[1]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
